// File: rtl/mult_div_ctrl.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and 32/32 divider (restoring on magnitudes).
// Optional cancellation through the abort port is compiled in with `define MULT_DIV_ABORT_EN.
module mult_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateT;

  stateT       state;
  stateT       nextState;
  logic [4:0]  iterCount;
  logic [32:0] accReg;
  logic [31:0] qReg;
  logic [31:0] mReg;
  logic        qm1;
  logic        negQuot;
  logic        negRem;
  logic        div0Reg;

  logic        abortHit;
  logic        acceptMult;
  logic        acceptDiv;
  logic        divByZero;
  logic        lastIter;
  logic [31:0] absA;
  logic [31:0] absB;

  logic [32:0] mExt;
  logic [32:0] boothSum;
  logic [32:0] boothAcc;
  logic [31:0] boothQ;
  logic [32:0] divShift;
  logic [33:0] divDiff;
  logic [32:0] divAcc;
  logic [31:0] divQ;
  logic [31:0] quotOut;
  logic [31:0] remOut;

`ifdef MULT_DIV_ABORT_EN
  assign abortHit = abort;
`else
  logic unusedAbort;
  assign unusedAbort = abort;
  assign abortHit    = 1'b0;
`endif

  // Multiply takes priority when both starts arrive together.
  assign acceptMult = (state == IDLE) && start_mult;
  assign acceptDiv  = (state == IDLE) && !start_mult && start_div;
  assign divByZero  = (b == 32'd0);
  assign lastIter   = (iterCount == 5'd31);
  assign absA       = a[31] ? (32'd0 - a) : a;
  assign absB       = b[31] ? (32'd0 - b) : b;

  // One Booth step and one restoring-division step, computed from the working registers.
  // The 33-bit accumulator keeps -2^31 multiplicands from overflowing.
  always_comb begin
    mExt     = {mReg[31], mReg};
    boothSum = accReg;
    case ({qReg[0], qm1})
      2'b01:   boothSum = accReg + mExt;
      2'b10:   boothSum = accReg - mExt;
      default: boothSum = accReg;
    endcase
    boothAcc = {boothSum[32], boothSum[32:1]};
    boothQ   = {boothSum[0], qReg[31:1]};

    divShift = {accReg[31:0], qReg[31]};
    divDiff  = {1'b0, divShift} - {2'b00, mReg};
    divAcc   = divDiff[33] ? divShift : divDiff[32:0];
    divQ     = {qReg[30:0], ~divDiff[33]};
    quotOut  = negQuot ? (32'd0 - divQ) : divQ;
    remOut   = negRem ? (32'd0 - divAcc[31:0]) : divAcc[31:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; a zero divisor skips straight to DONE to report div0.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (acceptMult) begin
          nextState = MULT;
        end else if (acceptDiv) begin
          nextState = divByZero ? DONE : DIV;
        end
      end
      MULT, DIV: begin
        if (abortHit) begin
          nextState = IDLE;
        end else if (lastIter) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: operands latched on acceptance, one iteration per cycle, result loaded on the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      iterCount <= 5'd0;
      accReg    <= 33'd0;
      qReg      <= 32'd0;
      mReg      <= 32'd0;
      qm1       <= 1'b0;
      negQuot   <= 1'b0;
      negRem    <= 1'b0;
      div0Reg   <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptMult) begin
            iterCount <= 5'd0;
            accReg    <= 33'd0;
            qReg      <= b;
            mReg      <= a;
            qm1       <= 1'b0;
            div0Reg   <= 1'b0;
          end else if (acceptDiv) begin
            iterCount <= 5'd0;
            accReg    <= 33'd0;
            qReg      <= absA;
            mReg      <= absB;
            qm1       <= 1'b0;
            negQuot   <= a[31] ^ b[31];
            negRem    <= a[31];
            div0Reg   <= divByZero;
          end
        end
        MULT: begin
          if (abortHit) begin
            iterCount <= 5'd0;
          end else begin
            iterCount <= iterCount + 5'd1;
            accReg    <= boothAcc;
            qReg      <= boothQ;
            qm1       <= qReg[0];
            if (lastIter) begin
              hi <= boothAcc[31:0];
              lo <= boothQ;
            end
          end
        end
        DIV: begin
          if (abortHit) begin
            iterCount <= 5'd0;
          end else begin
            iterCount <= iterCount + 5'd1;
            accReg    <= divAcc;
            qReg      <= divQ;
            if (lastIter) begin
              hi <= remOut;
              lo <= quotOut;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state == MULT) || (state == DIV);
    done = (state == DONE);
    div0 = (state == DONE) && div0Reg;
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed cases plus random operations
// checked against a plain-arithmetic reference model.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic        abort;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int fails  = 0;

  logic        busyTr [0:40];
  logic        div0Tr [0:40];
  logic [31:0] hiTr   [0:40];
  logic [31:0] loTr   [0:40];
  int          doneCycle;
  int          doneCount;
  int          busyCycles;
  logic [31:0] expHi;
  logic [31:0] expLo;

  always #5 clk = ~clk;

  mult_div_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start_mult(start_mult),
    .start_div(start_div),
    .abort(abort),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div0(div0),
    .hi(hi),
    .lo(lo)
  );

  function automatic logic [63:0] refMul(input logic [31:0] x, input logic [31:0] y);
    longint px;
    longint py;
    longint p;
    px = $signed(x);
    py = $signed(y);
    p  = px * py;
    return p;
  endfunction

  // Returns {remainder, quotient}; SV integer division truncates toward zero.
  function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y);
    longint dx;
    longint dy;
    longint q;
    longint r;
    dx = $signed(x);
    dy = $signed(y);
    q  = dx / dy;
    r  = dx % dy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a start at edge 0, then drives one-edge pulses of start/reset/abort at the given
  // edge numbers (-1 for none) while scrambling a/b; traces outputs over 40 cycles.
  task automatic applyStimulus(input bit mul, input bit dv, input logic [31:0] aVal,
                               input logic [31:0] bVal, input int injEdge,
                               input int rstEdge, input int abtEdge);
    @(negedge clk);
    a          = aVal;
    b          = bVal;
    start_mult = mul;
    start_div  = dv;
    abort      = 1'b0;
    reset      = 1'b0;
    doneCycle  = 0;
    doneCount  = 0;
    busyCycles = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      busyTr[cyc] = busy;
      div0Tr[cyc] = div0;
      hiTr[cyc]   = hi;
      loTr[cyc]   = lo;
      if (busy) busyCycles++;
      if (done) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = cyc;
      end
      a          = $urandom;
      b          = $urandom;
      start_mult = (cyc == injEdge);
      start_div  = (cyc == injEdge);
      reset      = (cyc == rstEdge);
      abort      = (cyc == abtEdge);
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    reset      = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic runOp(input string tag, input bit mul, input bit dv,
                       input logic [31:0] aVal, input logic [31:0] bVal);
    logic [63:0] r;
    int          expCyc;
    int          expBusy;
    logic        expDiv0;
    applyStimulus(mul, dv, aVal, bVal, -1, -1, -1);
    if (mul) begin
      r       = refMul(aVal, bVal);
      expHi   = r[63:32];
      expLo   = r[31:0];
      expCyc  = 33;
      expBusy = 32;
      expDiv0 = 1'b0;
    end else if (bVal == 32'd0) begin
      expCyc  = 1;
      expBusy = 0;
      expDiv0 = 1'b1;
    end else begin
      r       = refDiv(aVal, bVal);
      expHi   = r[63:32];
      expLo   = r[31:0];
      expCyc  = 33;
      expBusy = 32;
      expDiv0 = 1'b0;
    end
    checkOutput({tag, ".doneCycle"}, doneCycle, expCyc);
    checkOutput({tag, ".doneCount"}, doneCount, 1);
    checkOutput({tag, ".busyCycles"}, busyCycles, expBusy);
    checkOutput({tag, ".div0"}, div0Tr[doneCycle], expDiv0);
    checkOutput({tag, ".hi"}, hiTr[doneCycle], expHi);
    checkOutput({tag, ".lo"}, loTr[doneCycle], expLo);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rMul;

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    abort      = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.div0", div0, 0);
    checkOutput("reset.hi", hi, 0);
    checkOutput("reset.lo", lo, 0);
    reset = 1'b0;
    expHi = 32'd0;
    expLo = 32'd0;

    runOp("mul7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    checkOutput("mul7xm3.hiConst", hiTr[doneCycle], 32'hFFFFFFFF);
    checkOutput("mul7xm3.loConst", loTr[doneCycle], 32'hFFFFFFEB);

    runOp("div100bym7", 1'b0, 1'b1, 32'd100, 32'hFFFFFFF9);
    checkOutput("div100bym7.loConst", loTr[doneCycle], 32'hFFFFFFF2);
    checkOutput("div100bym7.hiConst", hiTr[doneCycle], 32'h00000002);

    runOp("divMinByM1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("divMinByM1.loConst", loTr[doneCycle], 32'h80000000);
    checkOutput("divMinByM1.hiConst", hiTr[doneCycle], 32'h00000000);

    runOp("preload", 1'b0, 1'b1, 32'h56781234, 32'h00010000);
    runOp("div5by0", 1'b0, 1'b1, 32'd5, 32'd0);
    checkOutput("div5by0.hiConst", hiTr[doneCycle], 32'h00001234);
    checkOutput("div5by0.loConst", loTr[doneCycle], 32'h00005678);

    applyStimulus(1'b1, 1'b1, 32'd2, 32'd3, 10, -1, -1);
    checkOutput("bothStarts.doneCycle", doneCycle, 33);
    checkOutput("bothStarts.doneCount", doneCount, 1);
    checkOutput("bothStarts.hi", hiTr[doneCycle], 32'd0);
    checkOutput("bothStarts.lo", loTr[doneCycle], 32'd6);

    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, 33, -1, -1);
    checkOutput("startInDone.doneCount", doneCount, 1);
    checkOutput("startInDone.busyAfter", busyTr[34], 0);
    checkOutput("startInDone.lo", loTr[doneCycle], 32'd14);
    checkOutput("startInDone.hi", hiTr[doneCycle], 32'd2);

    applyStimulus(1'b1, 1'b0, 32'h00012345, 32'hFFFF0001, -1, 10, -1);
    checkOutput("midReset.busyBefore", busyTr[10], 1);
    checkOutput("midReset.busy", busyTr[11], 0);
    checkOutput("midReset.hi", hiTr[11], 0);
    checkOutput("midReset.lo", loTr[11], 0);
    checkOutput("midReset.doneCount", doneCount, 0);
    expHi = 32'd0;
    expLo = 32'd0;

    runOp("preAbort", 1'b1, 1'b0, 32'h00012345, 32'h00006789);
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd3, -1, -1, 6);
`ifdef MULT_DIV_ABORT_EN
    checkOutput("abort.busyBefore", busyTr[6], 1);
    checkOutput("abort.busyAfter", busyTr[7], 0);
    checkOutput("abort.doneCount", doneCount, 0);
    checkOutput("abort.hi", hiTr[40], expHi);
    checkOutput("abort.lo", loTr[40], expLo);
`else
    checkOutput("abortIgnored.doneCycle", doneCycle, 33);
    checkOutput("abortIgnored.doneCount", doneCount, 1);
    checkOutput("abortIgnored.lo", loTr[doneCycle], 32'd333);
    checkOutput("abortIgnored.hi", hiTr[doneCycle], 32'd1);
    expHi = 32'd1;
    expLo = 32'd333;
`endif

    for (int i = 0; i < 14; i++) begin
      rMul = $urandom_range(0, 1) == 1;
      ra   = $urandom;
      rb   = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 20) - 10;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
      if (rMul) runOp($sformatf("randMul%0d", i), 1'b1, 1'b0, ra, rb);
      else      runOp($sformatf("randDiv%0d", i), 1'b0, 1'b1, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
